nrzi_rx_decoder: RTL and testbench

Serial NRZI line receiver and byte deserializer, built from library cells for the VLSI_PROYECTO_III datapath. It is the receive end of the NRZI link: the transmitter encodes a 0 as an inverted line level, and this block detects level inversions to recover the bits. It hunts for a sync byte, removes stuffed bits, packs LSB-first bytes, and presents them on a one-entry valid/ready output register with overrun and stuff-error flags.

---
 rtl/nrzi_rx_decoder_if.sv | 16 +
 rtl/nrzi_rx_decoder.sv | 154 +++++++++++++++
 tb/tb_nrzi_rx_decoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrzi_rx_decoder_if.sv
// NRZI receive link bundle: line input, consumer ready and the byte/flag outputs.
// Ports: D (line level), EN (line active), RDY (consumer ready);
//        Q (byte), QV (byte valid), OVR (sticky overrun), SERR (stuff-error pulse).
interface nrzi_rx_decoder_if;
  logic       D;
  logic       EN;
  logic       RDY;
  logic [7:0] Q;
  logic       QV;
  logic       OVR;
  logic       SERR;

  // master: the line/consumer side; slave: the decoder
  modport master (output D, EN, RDY, input Q, QV, OVR, SERR);
  modport slave  (input D, EN, RDY, output Q, QV, OVR, SERR);
endinterface

// File: rtl/nrzi_rx_decoder.sv
// NRZI receiver: decodes line inversions to bits, hunts for SYNC_BYTE, unstuffs, packs LSB-first bytes.
// Latency: Q/QV load at the edge sampling the 8th data bit; SERR pulses the cycle after a bad stuff bit.
// Backpressure: one-entry Q/QV register; a byte arriving while QV=1 and RDY=0 is dropped and sets sticky OVR.
// Ports: C (clock), RN (sync active-low reset), bus (nrzi_rx_decoder_if.slave).
// Build option: define NRZI_UNSTUFF_EN to build the stuffed-bit removal and SERR logic.
module nrzi_rx_decoder #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic             C,
  input  logic             RN,
  nrzi_rx_decoder_if.slave bus
);

  typedef enum logic {
    S_HUNT = 1'b0,
    S_DATA = 1'b1
  } state_t;

  // The ones counter is 3 bits wide, so the run length must fit in it.
  if (STUFF_LEN < 2 || STUFF_LEN > 7) begin : g_bad_stuff_len
    $error("nrzi_rx_decoder: STUFF_LEN must be in 2..7");
  end

  state_t     r_state, w_state_nxt;
  logic       r_prev,  w_prev_nxt;
  logic [7:0] r_shr,   w_shr_nxt;
  logic [2:0] r_bc,    w_bc_nxt;
  logic [7:0] r_q,     w_q_nxt;
  logic       r_qv,    w_qv_nxt;
  logic       r_ovr,   w_ovr_nxt;

  logic       w_bit;
  logic [7:0] w_shr_shift;
  logic       w_take;

`ifdef NRZI_UNSTUFF_EN
  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);
  logic [2:0] r_ones, w_ones_nxt;
  logic       r_serr, w_serr_nxt;
`endif

  // No transition on the line decodes to 1, an inversion decodes to 0.
  assign w_bit       = ~(bus.D ^ r_prev);
  assign w_shr_shift = {w_bit, r_shr[7:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_shr_nxt   = r_shr;
    w_bc_nxt    = r_bc;
    w_q_nxt     = r_q;
    w_qv_nxt    = r_qv & ~bus.RDY;   // a transfer drops QV unless a new byte reloads it below
    w_ovr_nxt   = r_ovr;
    w_take      = 1'b0;
`ifdef NRZI_UNSTUFF_EN
    w_ones_nxt  = r_ones;
    w_serr_nxt  = 1'b0;
`endif

    if (!bus.EN) begin
      // Line idle/abort: back to hunting; any pending output byte is kept.
      w_state_nxt = S_HUNT;
      w_prev_nxt  = 1'b1;
      w_shr_nxt   = 8'h00;
      w_bc_nxt    = 3'd0;
`ifdef NRZI_UNSTUFF_EN
      w_ones_nxt  = 3'd0;
`endif
    end else begin
      w_prev_nxt = bus.D;
      if (r_state == S_HUNT) begin
        w_shr_nxt = w_shr_shift;
        if (w_shr_shift == SYNC_BYTE) begin
          w_state_nxt = S_DATA;
          w_bc_nxt    = 3'd0;
`ifdef NRZI_UNSTUFF_EN
          w_ones_nxt  = 3'd0;
`endif
        end
      end else begin
        w_take = 1'b1;
`ifdef NRZI_UNSTUFF_EN
        if (r_ones == STUFF_CNT) begin
          // Stuff slot: a 0 is the transmitter's filler bit; a 1 means the framing is broken.
          w_take     = 1'b0;
          w_ones_nxt = 3'd0;
          if (w_bit) begin
            w_serr_nxt  = 1'b1;
            w_state_nxt = S_HUNT;
            w_shr_nxt   = 8'h00;
            w_bc_nxt    = 3'd0;
          end
        end else begin
          w_ones_nxt = w_bit ? (r_ones + 3'd1) : 3'd0;
        end
`endif
        if (w_take) begin
          w_shr_nxt = w_shr_shift;
          if (r_bc == 3'd7) begin
            w_bc_nxt = 3'd0;
            // Load if the output slot is empty or is being drained at this same edge.
            if (!r_qv || bus.RDY) begin
              w_q_nxt  = w_shr_shift;
              w_qv_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_bc_nxt = r_bc + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      r_state <= S_HUNT;
      r_prev  <= 1'b1;
      r_shr   <= 8'h00;
      r_bc    <= 3'd0;
      r_q     <= 8'h00;
      r_qv    <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef NRZI_UNSTUFF_EN
      r_ones  <= 3'd0;
      r_serr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_shr   <= w_shr_nxt;
      r_bc    <= w_bc_nxt;
      r_q     <= w_q_nxt;
      r_qv    <= w_qv_nxt;
      r_ovr   <= w_ovr_nxt;
`ifdef NRZI_UNSTUFF_EN
      r_ones  <= w_ones_nxt;
      r_serr  <= w_serr_nxt;
`endif
    end
  end

  assign bus.Q   = r_q;
  assign bus.QV  = r_qv;
  assign bus.OVR = r_ovr;
`ifdef NRZI_UNSTUFF_EN
  assign bus.SERR = r_serr;
`else
  assign bus.SERR = 1'b0;
`endif

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Bench for nrzi_rx_decoder: directed NRZI frames with a scoreboard of expected bytes/SERR pulses.
// Stimulus changes 1 time unit after the rising edge; the monitor samples on the falling edge.
// Build option: NRZI_UNSTUFF_EN selects the stuffing-aware expectations.
module tb_nrzi_rx_decoder;
  localparam int STUFF_LEN = 6;

  typedef struct packed {
    logic       serr;
    logic [7:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rn;
  logic line;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
`ifdef NRZI_UNSTUFF_EN
  int   ones = 0;
`endif

  nrzi_rx_decoder_if bus_if();

  nrzi_rx_decoder #(.SYNC_BYTE(8'h80), .STUFF_LEN(STUFF_LEN)) dut (
    .C  (clk),
    .RN (rn),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, expv);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_t e;
    e.serr = 1'b0;
    e.dat  = b;
    exp_q.push_back(e);
  endtask

  task automatic push_serr();
    exp_t e;
    e.serr = 1'b1;
    e.dat  = 8'h00;
    exp_q.push_back(e);
  endtask

  // Encode one decoded bit onto the line (0 = invert) and let the DUT sample it.
  task automatic send_bit(input logic b);
    if (!b) line = ~line;
    bus_if.D  = line;
    bus_if.EN = 1'b1;
    @(posedge clk); #1;
  endtask

  // Data bit with transmitter-side stuffing when the unstuffer is built.
  task automatic send_data_bit(input logic b);
    send_bit(b);
`ifdef NRZI_UNSTUFF_EN
    if (b) begin
      ones++;
      if (ones == STUFF_LEN) begin
        send_bit(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
`endif
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = 8'h80;
`ifdef NRZI_UNSTUFF_EN
    ones = 0;
`endif
    for (int i = 0; i < 8; i++) send_bit(s[i]);
  endtask

  task automatic send_data_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic end_frame();
    bus_if.EN = 1'b0;
    bus_if.D  = 1'b1;
    line      = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rn         = 1'b0;
    bus_if.EN  = 1'b0;
    bus_if.RDY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_if.D = ~bus_if.D;
      @(posedge clk); #1;
    end
    rn       = 1'b1;
    bus_if.D = 1'b1;
    line     = 1'b1;
  endtask

  // Monitor: every SERR pulse and every QV&RDY transfer must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.SERR === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL serr_event: got unexpected SERR pulse, expected no event");
        end else begin
          e = exp_q.pop_front();
          if (!e.serr) begin
            n_bad++;
            $display("FAIL serr_event: got SERR pulse, expected byte %02h", e.dat);
          end
        end
      end
      if (bus_if.QV === 1'b1 && bus_if.RDY === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL byte_xfer: got unexpected byte %02h, expected no event", bus_if.Q);
        end else begin
          e = exp_q.pop_front();
          if (e.serr) begin
            n_bad++;
            $display("FAIL byte_xfer: got byte %02h, expected SERR pulse", bus_if.Q);
          end else if (bus_if.Q !== e.dat) begin
            n_bad++;
            $display("FAIL byte_xfer: got %02h, expected %02h", bus_if.Q, e.dat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.D   = 1'b0;
    bus_if.EN  = 1'b0;
    bus_if.RDY = 1'b0;
    rn         = 1'b0;
    line       = 1'b1;

    // Reset with the line toggling
    do_reset();
    check("reset_q",    bus_if.Q,          8'h00);
    check("reset_qv",   {7'd0, bus_if.QV},   8'h00);
    check("reset_ovr",  {7'd0, bus_if.OVR},  8'h00);
    check("reset_serr", {7'd0, bus_if.SERR}, 8'h00);
    bus_if.RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("idle_qv", {7'd0, bus_if.QV}, 8'h00);

    // Sync then 0x00: D = 0,1,0,1,0,1,0,0 then 1,0,1,0,1,0,1,0
    push_byte(8'h00);
    send_sync();
    send_data_byte(8'h00);
    check("sync_byte_qv", {7'd0, bus_if.QV}, 8'h01);
    check("sync_byte_q",  bus_if.Q,          8'h00);
    end_frame();
    check("sync_byte_qv_clear", {7'd0, bus_if.QV}, 8'h00);

    // Six 1s, a transition, two 1s
`ifdef NRZI_UNSTUFF_EN
    push_byte(8'hFF);
`else
    push_byte(8'hBF);
`endif
    send_sync();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    check("stuff_partial_qv", {7'd0, bus_if.QV}, 8'h00);
`ifdef NRZI_UNSTUFF_EN
    send_bit(1'b1);
    send_bit(1'b1);
    check("stuff_q", bus_if.Q, 8'hFF);
`else
    send_bit(1'b1);
    check("stuff_q", bus_if.Q, 8'hBF);
`endif
    check("stuff_qv", {7'd0, bus_if.QV}, 8'h01);
    end_frame();

    // Non-transition in the stuff slot
`ifdef NRZI_UNSTUFF_EN
    send_sync();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    push_serr();
    send_bit(1'b1);
    check("serr_pulse", {7'd0, bus_if.SERR}, 8'h01);
    end_frame();
    check("serr_one_cycle", {7'd0, bus_if.SERR}, 8'h00);
    check("serr_no_qv",     {7'd0, bus_if.QV},   8'h00);
`else
    check("serr_tied", {7'd0, bus_if.SERR}, 8'h00);
`endif

    // Abort after 4 data bits, then a full frame
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    end_frame();
    check("abort_no_qv", {7'd0, bus_if.QV}, 8'h00);
    push_byte(8'h3C);
    send_sync();
    send_data_byte(8'h3C);
    check("abort_resend_q", bus_if.Q, 8'h3C);
    end_frame();

    // Overrun: RDY held low across two bytes
    bus_if.RDY = 1'b0;
    send_sync();
    send_data_byte(8'h12);
    check("ovr_first_q",   bus_if.Q,           8'h12);
    check("ovr_first_ovr", {7'd0, bus_if.OVR}, 8'h00);
    send_data_byte(8'h34);
    check("ovr_second_q",   bus_if.Q,           8'h12);
    check("ovr_second_qv",  {7'd0, bus_if.QV},  8'h01);
    check("ovr_second_ovr", {7'd0, bus_if.OVR}, 8'h01);
    end_frame();
    check("ovr_sticky", {7'd0, bus_if.OVR}, 8'h01);
    push_byte(8'h12);
    bus_if.RDY = 1'b1;
    @(posedge clk); #1;
    check("ovr_drain_qv", {7'd0, bus_if.QV},  8'h00);
    check("ovr_kept",     {7'd0, bus_if.OVR}, 8'h01);

    // Reset clears OVR
    do_reset();
    check("reset2_ovr", {7'd0, bus_if.OVR}, 8'h00);
    check("reset2_q",   bus_if.Q,           8'h00);

    // Back-to-back with RDY high
    bus_if.RDY = 1'b1;
    push_byte(8'hA5);
    push_byte(8'h5A);
    send_sync();
    send_data_byte(8'hA5);
    check("b2b_first_q", bus_if.Q, 8'hA5);
    send_data_byte(8'h5A);
    check("b2b_second_q", bus_if.Q, 8'h5A);
    end_frame();
    check("b2b_ovr", {7'd0, bus_if.OVR}, 8'h00);

    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d events outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
